// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bundle between next-PC/control logic and the pc_unit.
interface pc_unit_if #(
  parameter int WIDTH  = 32,
  parameter int NSTALL = 4
);
  logic [NSTALL-1:0] stall;
  logic [1:0]        npc_sel;
  logic [15:0]       branch_off;
  logic [WIDTH-1:0]  jump_target;
  logic [WIDTH-1:0]  reg_target;
  logic              exc_req;
  logic              eret;
  logic [WIDTH-1:0]  pc_out;
  logic [WIDTH-1:0]  pc_plus4;
  logic [WIDTH-1:0]  epc;
  logic              in_exc;
  logic [15:0]       stall_cnt;
  modport master (
    output stall, npc_sel, branch_off, jump_target, reg_target, exc_req, eret,
    input  pc_out, pc_plus4, epc, in_exc, stall_cnt
  );
  modport slave (
    input  stall, npc_sel, branch_off, jump_target, reg_target, exc_req, eret,
    output pc_out, pc_plus4, epc, in_exc, stall_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with 4-way next-PC select, N-source stall, exception entry and eret.
// Optional PC_MISALIGN_TRAP_EN turns a misaligned selected next PC into an exception.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter int               NSTALL    = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180)
) (
  input logic     Clk,
  input logic     Reset,
  pc_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, HOLD, TRAP} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_pc, r_epc;
  logic             r_in_exc;
  logic [15:0]      r_cnt;
  logic [WIDTH-1:0] w_pc_plus4, w_boff, w_npc;
  logic             w_stall;
  assign w_pc_plus4 = r_pc + WIDTH'(4);
  assign w_boff     = WIDTH'($signed(bus.branch_off)) << 2;
  assign w_stall    = |bus.stall;
  always_comb
    w_npc = bus.npc_sel == 2'd0 ? w_pc_plus4 :
            bus.npc_sel == 2'd1 ? w_pc_plus4 + w_boff :
            bus.npc_sel == 2'd2 ? bus.jump_target : bus.reg_target;
  // Exception entry outranks stall; eret in TRAP outranks a repeated exc_req.
  always_ff @(posedge Clk)
    if (Reset) begin
      r_state  <= RUN;
      r_pc     <= RESET_VEC;
      r_epc    <= '0;
      r_in_exc <= 1'b0;
      r_cnt    <= '0;
    end else if (bus.exc_req && r_state != TRAP) begin
      r_state  <= TRAP;
      r_epc    <= r_pc;
      r_pc     <= EXC_VEC;
      r_in_exc <= 1'b1;
      r_cnt    <= '0;
    end else if (w_stall) begin
      r_cnt <= &r_cnt ? r_cnt : r_cnt + 16'd1;
      if (r_state == RUN) r_state <= HOLD;
    end else if (bus.eret && r_state == TRAP) begin
      r_state  <= RUN;
      r_pc     <= r_epc;
      r_in_exc <= 1'b0;
      r_cnt    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
    end else if (|w_npc[1:0]) begin
      if (r_state != TRAP) r_epc <= w_npc;
      r_state  <= TRAP;
      r_pc     <= EXC_VEC;
      r_in_exc <= 1'b1;
      r_cnt    <= '0;
`endif
    end else begin
      r_pc  <= w_npc;
      r_cnt <= '0;
      if (r_state == HOLD) r_state <= RUN;
    end
  assign bus.pc_out    = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.epc       = r_epc;
  assign bus.in_exc    = r_in_exc;
  assign bus.stall_cnt = r_cnt;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a behavioural model.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] m_pc, m_epc;
  logic        m_exc;
  int          m_cnt;
  pc_unit_if #(.WIDTH(32), .NSTALL(4)) bus ();
  pc_unit #(.WIDTH(32), .NSTALL(4)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cycle(input logic r, input logic [3:0] s, input logic [1:0] sel,
                       input logic [15:0] off, input logic [31:0] jt, input logic [31:0] rt,
                       input logic ex, input logic er);
    logic [31:0] t, b;
    rst = r; bus.stall = s; bus.npc_sel = sel; bus.branch_off = off;
    bus.jump_target = jt; bus.reg_target = rt; bus.exc_req = ex; bus.eret = er;
    @(posedge clk);
    b = {{16{off[15]}}, off};
    t = sel == 2'd0 ? m_pc + 32'd4 : sel == 2'd1 ? m_pc + 32'd4 + b * 32'd4 : sel == 2'd2 ? jt : rt;
    if (r) begin
      m_pc = 32'h3000; m_epc = 0; m_exc = 0; m_cnt = 0;
    end else if (ex && !m_exc) begin
      m_epc = m_pc; m_pc = 32'h4180; m_exc = 1; m_cnt = 0;
    end else if (s != 0) begin
      m_cnt = m_cnt == 65535 ? 65535 : m_cnt + 1;
    end else if (er && m_exc) begin
      m_pc = m_epc; m_exc = 0; m_cnt = 0;
    end else begin
      m_cnt = 0;
`ifdef PC_MISALIGN_TRAP_EN
      if (t[1:0] != 0) begin
        if (!m_exc) m_epc = t;
        m_pc = 32'h4180; m_exc = 1;
      end else m_pc = t;
`else
      m_pc = t;
`endif
    end
    #1;
  endtask
  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (bus.pc_out !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h want 3000", bus.pc_out); end
    n_chk++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want 0", bus.epc); end
    n_chk++; if (bus.in_exc !== 1'b0 || bus.stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_flags got %b/%h want 0/0", bus.in_exc, bus.stall_cnt); end
    n_chk++; if (bus.pc_plus4 !== 32'h3004) begin n_fail++; $display("FAIL reset_plus4 got %h want 3004", bus.pc_plus4); end
  endtask
  task automatic test_sequential;
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (bus.pc_out !== 32'h3004) begin n_fail++; $display("FAIL seq1 got %h want 3004", bus.pc_out); end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (bus.pc_out !== 32'h3008 || bus.epc !== 0) begin n_fail++; $display("FAIL seq2 got %h/%h want 3008/0", bus.pc_out, bus.epc); end
  endtask
  task automatic test_stall;
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 4'b0100, 0, 0, 0, 0, 0, 0);
      n_chk++; if (bus.pc_out !== 32'h3008 || bus.stall_cnt !== 16'(i)) begin n_fail++; $display("FAIL stall%0d got %h/%0d want 3008/%0d", i, bus.pc_out, bus.stall_cnt, i); end
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (bus.pc_out !== 32'h300C || bus.stall_cnt !== 0) begin n_fail++; $display("FAIL stall_release got %h/%0d want 300c/0", bus.pc_out, bus.stall_cnt); end
  endtask
  task automatic test_branch_jump;
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 16'hFFFC, 0, 0, 0, 0);
    n_chk++; if (bus.pc_out !== 32'h3004) begin n_fail++; $display("FAIL branch_back got %h want 3004", bus.pc_out); end
    cycle(0, 0, 2, 0, 32'h5000, 0, 0, 0);
    n_chk++; if (bus.pc_out !== 32'h5000) begin n_fail++; $display("FAIL jump got %h want 5000", bus.pc_out); end
    cycle(0, 0, 1, 16'h0010, 0, 0, 0, 0);
    n_chk++; if (bus.pc_out !== 32'h5044) begin n_fail++; $display("FAIL branch_fwd got %h want 5044", bus.pc_out); end
  endtask
  task automatic test_exception;
    cycle(0, 0, 2, 0, 32'h3020, 0, 0, 0);
    cycle(0, 4'b0001, 0, 0, 0, 0, 1, 0);
    n_chk++; if (bus.pc_out !== 32'h4180 || bus.epc !== 32'h3020 || bus.in_exc !== 1'b1) begin n_fail++; $display("FAIL exc_entry got %h/%h/%b want 4180/3020/1", bus.pc_out, bus.epc, bus.in_exc); end
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    n_chk++; if (bus.pc_out !== 32'h4184 || bus.epc !== 32'h3020 || bus.in_exc !== 1'b1) begin n_fail++; $display("FAIL exc_nested got %h/%h/%b want 4184/3020/1", bus.pc_out, bus.epc, bus.in_exc); end
    cycle(0, 4'b1000, 0, 0, 0, 0, 0, 1);
    n_chk++; if (bus.pc_out !== 32'h4184 || bus.in_exc !== 1'b1 || bus.stall_cnt !== 1) begin n_fail++; $display("FAIL eret_stalled got %h/%b/%0d want 4184/1/1", bus.pc_out, bus.in_exc, bus.stall_cnt); end
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    n_chk++; if (bus.pc_out !== 32'h3020 || bus.in_exc !== 1'b0) begin n_fail++; $display("FAIL eret got %h/%b want 3020/0", bus.pc_out, bus.in_exc); end
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    n_chk++; if (bus.pc_out !== 32'h3024) begin n_fail++; $display("FAIL eret_outside got %h want 3024", bus.pc_out); end
  endtask
  task automatic test_reset_in_trap;
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 4'b0010, 0, 0, 0, 0, 1, 0);
    n_chk++; if (bus.pc_out !== 32'h3000 || bus.in_exc !== 0 || bus.epc !== 0) begin n_fail++; $display("FAIL reset_trap got %h/%b/%h want 3000/0/0", bus.pc_out, bus.in_exc, bus.epc); end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_misalign;
    cycle(0, 0, 3, 0, 0, 32'h3006, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
    n_chk++; if (bus.pc_out !== 32'h4180 || bus.epc !== 32'h3006 || bus.in_exc !== 1) begin n_fail++; $display("FAIL misalign got %h/%h want 4180/3006", bus.pc_out, bus.epc); end
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
`else
    n_chk++; if (bus.pc_out !== 32'h3006 || bus.in_exc !== 0) begin n_fail++; $display("FAIL misalign got %h/%b want 3006/0", bus.pc_out, bus.in_exc); end
`endif
  endtask
  task automatic test_wrap;
    cycle(0, 0, 3, 0, 0, 32'hFFFF_FFFC, 0, 0);
    n_chk++; if (bus.pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4 got %h want 0", bus.pc_plus4); end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap got %h want 0", bus.pc_out); end
  endtask
  task automatic test_saturate;
    for (int i = 0; i < 65537; i++) cycle(0, 4'b1111, 0, 0, 0, 0, 0, 0);
    n_chk++; if (bus.stall_cnt !== 16'hFFFF || bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL saturate got %h/%h want ffff/0", bus.stall_cnt, bus.pc_out); end
    cycle(0, 4'b0001, 0, 0, 0, 0, 1, 0);
    n_chk++; if (bus.stall_cnt !== 16'h0 || bus.pc_out !== 32'h4180) begin n_fail++; $display("FAIL exc_clears_cnt got %h/%h want 0/4180", bus.stall_cnt, bus.pc_out); end
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_random;
    logic [31:0] jt, rt;
    for (int i = 0; i < 400; i++) begin
      jt = $urandom; rt = $urandom;
      if ($urandom_range(0, 3) != 0) begin jt[1:0] = 0; rt[1:0] = 0; end
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0,
            2'($urandom), 16'($urandom), jt, rt, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      n_chk++;
      if (bus.pc_out !== m_pc || bus.pc_plus4 !== m_pc + 32'd4 || bus.epc !== m_epc ||
          bus.in_exc !== m_exc || bus.stall_cnt !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand%0d got pc=%h epc=%h exc=%b cnt=%0d want pc=%h epc=%h exc=%b cnt=%0d",
                 i, bus.pc_out, bus.epc, bus.in_exc, bus.stall_cnt, m_pc, m_epc, m_exc, m_cnt);
      end
    end
  endtask
  initial begin
    m_pc = 0; m_epc = 0; m_exc = 0; m_cnt = 0;
    test_reset;
    test_sequential;
    test_stall;
    test_branch_jump;
    test_exception;
    test_reset_in_trap;
    test_misalign;
    test_wrap;
    test_saturate;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multi-cycle CPU, replacing the fixed 32-bit PC register. It selects the next fetch address from four sources and holds on any of N stall sources. It also takes exceptions to a fixed vector, saves the return address in EPC, and returns on `eret`. It sits between the control unit / next-PC logic and instruction memory, and drives the fetch address every cycle.

## Interface
Parameters:
- `WIDTH`, 32: address width, ≥ 8.
- `NSTALL`, 4: number of independent stall sources.
- `RESET_VEC`, 32'h0000_3000: PC value after reset.
- `EXC_VEC`, 32'h0000_4180: exception handler entry address.

Ports:
- `Clk`  in  1: clock, rising edge.
- `Reset`  in  1: synchronous active-high reset.
- `stall`  in  NSTALL: stall requests; any bit set holds the PC.
- `npc_sel`  in  2: next-PC source. 0 = sequential, 1 = branch, 2 = jump, 3 = register.
- `branch_off`  in  16: signed word offset.
- `jump_target`  in  WIDTH: absolute jump address.
- `reg_target`  in  WIDTH: register-indirect address.
- `exc_req`  in  1: exception request, sampled each cycle.
- `eret`  in  1: return from exception.
- `pc_out`  out  WIDTH: registered fetch address.
- `pc_plus4`  out  WIDTH: `pc_out + 4`, combinational.
- `epc`  out  WIDTH: saved exception return address.
- `in_exc`  out  1: high while in handler mode (TRAP state).
- `stall_cnt`  out  16: consecutive stalled cycles, saturating.

## Operation
- States: RUN, HOLD, TRAP.
- Per-edge priority, highest first: `Reset`, `exc_req`, stall, `eret`, `npc_sel`.
- Reset:
  - `pc_out` = RESET_VEC, `epc` = 0, `in_exc` = 0, `stall_cnt` = 0, state = RUN.
  - Reset overrides everything, including in the middle of HOLD or TRAP.
- Exception entry: `exc_req` in RUN or HOLD, when not in TRAP:
  - `epc` ← current `pc_out`; `pc_out` ← EXC_VEC; `in_exc` ← 1; state = TRAP.
  - Exception entry overrides stall; this is a flush.
- `exc_req` while in TRAP is ignored; no nesting.
- Stall: any `stall` bit set, and no exception taken:
  - `pc_out` holds; state = HOLD (or remains TRAP if already there).
  - `stall_cnt` increments and saturates at 16'hFFFF.
  - `stall_cnt` clears to 0 on the first unstalled edge.
- `eret` in TRAP, unstalled: `pc_out` ← `epc`; `in_exc` ← 0; state = RUN.
- `eret` outside TRAP is ignored; `npc_sel` applies as normal.
- Otherwise the next PC is selected by `npc_sel`:
  - 0: `pc_plus4`.
  - 1: `pc_plus4 + (sign_extend(branch_off) << 2)`, computed at WIDTH bits and wrapping modulo 2^WIDTH.
  - 2: `jump_target`.
  - 3: `reg_target`.
- HOLD → RUN on the first unstalled edge. That same edge also applies the selected next PC.
- Arithmetic: all additions are WIDTH-bit with carry discarded. For example, `pc_out` = all-ones−3 with sequential select wraps to 0.

## Timing
- `pc_out`, `epc`, `in_exc` and `stall_cnt` are registered and change only on the rising edge of `Clk`.
- Next-PC latency is one cycle. Inputs sampled at edge k appear on `pc_out` after edge k.
- `pc_plus4` follows `pc_out` combinationally within the same cycle.
- Stall acts in the same cycle it is sampled. No stall skid.
- `exc_req` and `stall` arriving together: the exception wins and `stall_cnt` clears.
- `exc_req` and `eret` arriving together in TRAP: `eret` is applied.

## Configuration
- Macro: `PC_MISALIGN_TRAP_EN`.
- Defined:
  - A selected next PC with bits [1:0] ≠ 0 from any source is treated as an exception.
  - `epc` ← the misaligned target; `pc_out` ← EXC_VEC; state = TRAP.
  - A misaligned target while already in TRAP loads `pc_out` ← EXC_VEC and leaves `epc` unchanged.
- Undefined: targets load unmodified and no alignment check exists.

## Test plan
- Reset held 2 cycles, then released with `npc_sel`=0 → `pc_out` = 3000, then 3004, then 3008; `epc` = 0.
- At `pc_out`=3010, `npc_sel`=1, `branch_off`=16'hFFFC → `pc_out` = 3004. Next cycle `npc_sel`=2, `jump_target`=5000 → `pc_out` = 5000.
- `stall`=4'b0100 for 3 cycles at `pc_out`=3008 → `pc_out` stays 3008 and `stall_cnt` = 1, 2, 3. On release → `pc_out` = 300C and `stall_cnt` = 0.
- `exc_req` at `pc_out`=3020 with `stall`=4'b0001 → `pc_out` = 4180, `epc` = 3020, `in_exc` = 1. A second `exc_req` in TRAP has no effect. `eret` → `pc_out` = 3020, `in_exc` = 0.
- Reset asserted in TRAP → `pc_out` = 3000, `in_exc` = 0, `epc` = 0.
- With `PC_MISALIGN_TRAP_EN`, `npc_sel`=3 and `reg_target`=3006 → `pc_out` = 4180, `epc` = 3006. Without the macro → `pc_out` = 3006.
